// File: rtl/tx_cmd_scheduler_pkg.sv
// Shared action codes, FSM state encoding and action-code helpers for the
// transmitter command scheduler.
package tx_cmd_pkg;

  localparam int unsigned ACT_W = 3;
  typedef logic [ACT_W-1:0] act_t;

  localparam act_t ACT_NOP  = 3'd0;
  localparam act_t ACT_LOAD = 3'd1;
  localparam act_t ACT_CELL = 3'd2;
  localparam act_t ACT_ROW  = 3'd3;
  localparam act_t ACT_COL  = 3'd4;
  localparam act_t ACT_ALL  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT_HI = 3'd2,
    S_WAIT_LO = 3'd3,
    S_ACK     = 3'd4
  } state_t;

  // Codes that start a frame and therefore raise transmitter busy.
  function automatic logic act_is_tx(input act_t a);
    return (a >= ACT_CELL) && (a <= ACT_ALL);
  endfunction

  function automatic logic act_is_valid(input act_t a);
    return (a == ACT_LOAD) || act_is_tx(a);
  endfunction

endpackage

// File: rtl/tx_cmd_scheduler_if.sv
// Requester-side command bus plus transmitter-side control bus of the
// scheduler; master is the scheduler, slave is the surrounding system.
interface tx_cmd_scheduler_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 8
);
  localparam int unsigned IW = $clog2(NREQ);

  logic [NREQ-1:0]   req;
  logic [3*NREQ-1:0] req_action;
  logic [NREQ-1:0]   req_row;
  logic [2*NREQ-1:0] req_col;
  logic [W*NREQ-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic              err;

  logic              tx_busy;
  logic [W-1:0]      tx_d;
  logic              tx_row;
  logic [1:0]        tx_col;
  logic [2:0]        tx_action;

  logic [IW-1:0]     grant_id;
  logic              active;

  modport master (
    input  req, req_action, req_row, req_col, req_data, tx_busy,
    output ack, err, tx_d, tx_row, tx_col, tx_action, grant_id, active
  );

  modport slave (
    output req, req_action, req_row, req_col, req_data, tx_busy,
    input  ack, err, tx_d, tx_row, tx_col, tx_action, grant_id, active
  );

endinterface

// File: rtl/tx_cmd_scheduler_rr_arbiter.sv
// Combinational round-robin select: first set request at or after i_ptr,
// wrapping from NREQ-1 back to 0.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]         o_gnt,
  output logic [$clog2(NREQ)-1:0] o_gnt_id,
  output logic                    o_any
);
  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned XW = IW + 1;

  logic [XW-1:0] w_idx;

  always_comb begin
    o_any    = 1'b0;
    o_gnt_id = '0;
    w_idx    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, i_ptr} + XW'(k);
      if (w_idx >= XW'(NREQ)) begin
        w_idx = w_idx - XW'(NREQ);
      end
      if (!o_any && i_req[w_idx[IW-1:0]]) begin
        o_any    = 1'b1;
        o_gnt_id = w_idx[IW-1:0];
      end
    end
    o_gnt = o_any ? (NREQ'(1'b1) << o_gnt_id) : '0;
  end

endmodule

// File: rtl/tx_cmd_scheduler.sv
// Shares one matrix UART transmitter between NREQ requesters: arbitrates,
// issues a one-cycle action pulse, tracks busy and returns a per-requester ack.
module tx_cmd_scheduler
  import tx_cmd_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned W        = 8,
  parameter int unsigned WAIT_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  tx_cmd_scheduler_if.master bus
);
  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(WAIT_MAX + 1);

  state_t          r_state, w_state_nx;
  logic [NREQ-1:0] r_ack, w_ack;
  logic            r_err, w_err;
  logic [W-1:0]    r_tx_d, w_tx_d;
  logic            r_tx_row, w_tx_row;
  logic [1:0]      r_tx_col, w_tx_col;
  act_t            r_tx_action, w_tx_action;
  logic [IW-1:0]   r_grant_id, w_grant_id;
  logic [IW-1:0]   r_ptr, w_ptr;
  logic [CW-1:0]   r_wcnt, w_wcnt;
  logic            r_active, w_active;

  logic [NREQ-1:0] w_gnt;
  logic [IW-1:0]   w_gnt_id;
  logic            w_any;
  act_t            w_sel_act;
  logic            w_sel_row;
  logic [1:0]      w_sel_col;
  logic [W-1:0]    w_sel_data;
  logic [NREQ-1:0] w_cur_onehot;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .o_gnt    (w_gnt),
    .o_gnt_id (w_gnt_id),
    .o_any    (w_any)
  );

  always_comb begin
    w_sel_act  = ACT_NOP;
    w_sel_row  = 1'b0;
    w_sel_col  = '0;
    w_sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_act  = bus.req_action[3*i +: 3];
        w_sel_row  = bus.req_row[i];
        w_sel_col  = bus.req_col[2*i +: 2];
        w_sel_data = bus.req_data[W*i +: W];
      end
    end
  end

  assign w_cur_onehot = NREQ'(1'b1) << r_grant_id;

  // ack/err are loaded on the transition into S_ACK so they are visible
  // exactly during the S_ACK cycle.
  always_comb begin
    w_state_nx  = r_state;
    w_ack       = '0;
    w_err       = 1'b0;
    w_tx_d      = r_tx_d;
    w_tx_row    = r_tx_row;
    w_tx_col    = r_tx_col;
    w_tx_action = ACT_NOP;
    w_grant_id  = r_grant_id;
    w_ptr       = r_ptr;
    w_wcnt      = r_wcnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_any && !bus.tx_busy) begin
          w_tx_d     = w_sel_data;
          w_tx_row   = w_sel_row;
          w_tx_col   = w_sel_col;
          w_grant_id = w_gnt_id;
          if (act_is_valid(w_sel_act)) begin
            w_tx_action = w_sel_act;
            w_state_nx  = S_ISSUE;
          end else begin
            w_ack      = w_gnt;
            w_err      = 1'b1;
            w_state_nx = S_ACK;
          end
        end
      end
      S_ISSUE: begin
        if (r_tx_action == ACT_LOAD) begin
          w_ack      = w_cur_onehot;
          w_state_nx = S_ACK;
        end else begin
          w_wcnt     = '0;
          w_state_nx = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (bus.tx_busy) begin
          w_state_nx = S_WAIT_LO;
        end else if (r_wcnt == CW'(WAIT_MAX - 1)) begin
          w_ack      = w_cur_onehot;
          w_err      = 1'b1;
          w_state_nx = S_ACK;
        end else begin
          w_wcnt = r_wcnt + CW'(1);
        end
      end
      S_WAIT_LO: begin
        if (!bus.tx_busy) begin
          w_ack      = w_cur_onehot;
          w_state_nx = S_ACK;
        end
      end
      S_ACK: begin
        w_ptr      = (r_grant_id == IW'(NREQ - 1)) ? '0 : r_grant_id + IW'(1);
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
    w_active = (w_state_nx != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ack       <= '0;
      r_err       <= 1'b0;
      r_tx_d      <= '0;
      r_tx_row    <= 1'b0;
      r_tx_col    <= '0;
      r_tx_action <= ACT_NOP;
      r_grant_id  <= '0;
      r_ptr       <= '0;
      r_wcnt      <= '0;
      r_active    <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_ack       <= w_ack;
      r_err       <= w_err;
      r_tx_d      <= w_tx_d;
      r_tx_row    <= w_tx_row;
      r_tx_col    <= w_tx_col;
      r_tx_action <= w_tx_action;
      r_grant_id  <= w_grant_id;
      r_ptr       <= w_ptr;
      r_wcnt      <= w_wcnt;
      r_active    <= w_active;
    end
  end

  assign bus.ack       = r_ack;
  assign bus.err       = r_err;
  assign bus.tx_d      = r_tx_d;
  assign bus.tx_row    = r_tx_row;
  assign bus.tx_col    = r_tx_col;
  assign bus.tx_action = r_tx_action;
  assign bus.grant_id  = r_grant_id;
  assign bus.active    = r_active;

endmodule

// File: tb/tb_tx_cmd_scheduler.sv
// Scoreboard bench for tx_cmd_scheduler with a behavioural transmitter model
// and a request-level round-robin reference model.
module tb_tx_cmd_scheduler;
  localparam int NREQ     = 4;
  localparam int W        = 8;
  localparam int WAIT_MAX = 4;

  typedef struct {
    int id;
    bit err;
    int lo;
    int hi;
    int t0;
  } ack_exp_t;

  typedef struct {
    logic [2:0]   code;
    logic [W-1:0] d;
    logic         row;
    logic [1:0]   col;
  } tx_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  ack_exp_t ackq[$];
  tx_exp_t  txq[$];

  logic [2:0]   p_act[NREQ];
  logic         p_row[NREQ];
  logic [1:0]   p_col[NREQ];
  logic [W-1:0] p_data[NREQ];
  int           mptr = 0;

  bit   tx_respond = 1'b1;
  bit   force_busy = 1'b0;
  int   busy_n = 4;
  logic mbusy = 1'b0;
  int   mcnt = 0;
  logic [2:0] prev_act = 3'd0;

  tx_cmd_scheduler_if #(.NREQ(NREQ), .W(W)) bus ();

  tx_cmd_scheduler #(.NREQ(NREQ), .W(W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.tx_busy = mbusy | force_busy;

  // Transmitter: busy rises the cycle after a frame action and lasts busy_n cycles.
  always @(posedge clk) begin
    if (rst) begin
      mbusy <= 1'b0;
      mcnt  <= 0;
    end else if (mbusy) begin
      if (mcnt <= 1) mbusy <= 1'b0;
      mcnt <= mcnt - 1;
    end else if (tx_respond && bus.tx_action >= 3'd2 && bus.tx_action <= 3'd5) begin
      mbusy <= 1'b1;
      mcnt  <= busy_n;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_act != 3'd0) chk("tx_pulse_width", bus.tx_action, 0);
      if (bus.tx_action != 3'd0 && prev_act == 3'd0) begin
        if (txq.size() == 0) begin
          chk("unexpected_tx", bus.tx_action, 0);
        end else begin
          tx_exp_t e;
          e = txq.pop_front();
          chk("tx_action", bus.tx_action, e.code);
          chk("tx_d", bus.tx_d, e.d);
          chk("tx_row", bus.tx_row, e.row);
          chk("tx_col", bus.tx_col, e.col);
        end
      end
      if (bus.ack != '0) begin
        if (ackq.size() == 0) begin
          chk("unexpected_ack", bus.ack, 0);
        end else begin
          ack_exp_t a;
          int lat;
          a = ackq.pop_front();
          lat = cyc - a.t0;
          chk("ack_vec", bus.ack, 64'(1) << a.id);
          chk("ack_err", bus.err, a.err);
          chk("grant_id", bus.grant_id, a.id);
          if (a.lo >= 0) begin
            if (a.lo == a.hi) chk("ack_latency", lat, a.lo);
            else if (lat < a.lo) chk("ack_latency_min", lat, a.lo);
            else chk("ack_latency_max", (lat > a.hi) ? lat : a.hi, a.hi);
          end
        end
      end
    end
    prev_act = bus.tx_action;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req = '0;
    @(negedge clk);
    chk("rst_ack", bus.ack, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_tx_d", bus.tx_d, 0);
    chk("rst_tx_row", bus.tx_row, 0);
    chk("rst_tx_col", bus.tx_col, 0);
    chk("rst_tx_action", bus.tx_action, 0);
    chk("rst_grant_id", bus.grant_id, 0);
    chk("rst_active", bus.active, 0);
    rst = 1'b0;
    mptr = 0;
  endtask

  // Reference: all requests of a phase held together are served in id order
  // rotated to start at the round-robin pointer.
  task automatic phase(input logic [NREQ-1:0] mask);
    int order[$];
    logic [NREQ-1:0] pending;
    bit act_ok;
    int budget;
    for (int k = 0; k < NREQ; k++) begin
      int id;
      id = (mptr + k) % NREQ;
      if (mask[id]) order.push_back(id);
    end
    foreach (order[j]) begin
      int id;
      ack_exp_t a;
      id = order[j];
      a.id = id;
      a.t0 = cyc;
      a.lo = -1;
      a.hi = -1;
      if (p_act[id] == 3'd1) begin
        a.err = 1'b0; a.lo = 2; a.hi = 2;
      end else if (p_act[id] >= 3'd2 && p_act[id] <= 3'd5) begin
        a.err = !tx_respond;
        if (tx_respond) begin a.lo = busy_n + 3; a.hi = busy_n + 3; end
        else begin a.lo = WAIT_MAX + 1; a.hi = WAIT_MAX + 2; end
      end else begin
        a.err = 1'b1; a.lo = 1; a.hi = 1;
      end
      if (order.size() != 1) begin a.lo = -1; a.hi = -1; end
      ackq.push_back(a);
      if (p_act[id] >= 3'd1 && p_act[id] <= 3'd5)
        txq.push_back('{code: p_act[id], d: p_data[id], row: p_row[id], col: p_col[id]});
    end
    mptr = (order[order.size()-1] + 1) % NREQ;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_action[3*i +: 3] = p_act[i];
      bus.req_row[i]           = p_row[i];
      bus.req_col[2*i +: 2]    = p_col[i];
      bus.req_data[W*i +: W]   = p_data[i];
    end
    bus.req = mask;
    pending = mask;
    act_ok = 1'b1;
    budget = 400;
    while (pending != '0 && budget > 0) begin
      @(negedge clk);
      budget--;
      if (!bus.active) act_ok = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (bus.ack[i] && pending[i]) begin
          pending[i] = 1'b0;
          bus.req[i] = 1'b0;
        end
      end
    end
    if (pending != '0) begin
      chk("phase_timeout", pending, 0);
      ackq.delete();
      txq.delete();
      do_reset();
    end else begin
      if (order.size() == 1) chk("active_during_cmd", act_ok, 1);
      @(negedge clk);
      chk("idle_active", bus.active, 0);
    end
  endtask

  initial begin
    bus.req = '0;
    bus.req_action = '0;
    bus.req_row = '0;
    bus.req_col = '0;
    bus.req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      p_act[i] = 3'd1; p_row[i] = 1'b0; p_col[i] = 2'd0; p_data[i] = '0;
    end
    repeat (2) @(negedge clk);
    do_reset();

    p_act[0] = 3'd1; p_row[0] = 1'b1; p_col[0] = 2'd2; p_data[0] = 8'hA5;
    phase(4'b0001);

    busy_n = 31;
    p_act[1] = 3'd2; p_row[1] = 1'b0; p_col[1] = 2'd3; p_data[1] = 8'h3C;
    phase(4'b0010);

    do_reset();
    busy_n = 4;
    for (int i = 0; i < NREQ; i++) begin
      p_act[i] = 3'd1; p_data[i] = W'($urandom); p_row[i] = 1'($urandom); p_col[i] = 2'($urandom);
    end
    phase(4'b1111);
    phase(4'b0101);

    p_act[2] = 3'd6;
    phase(4'b0100);
    tx_respond = 1'b0;
    p_act[2] = 3'd3;
    phase(4'b0100);
    tx_respond = 1'b1;

    force_busy = 1'b1;
    busy_n = 20;
    p_act[3] = 3'd4; p_row[3] = 1'b1; p_col[3] = 2'd1; p_data[3] = 8'h5A;
    bus.req_action[9 +: 3] = p_act[3];
    bus.req_row[3] = p_row[3];
    bus.req_col[6 +: 2] = p_col[3];
    bus.req_data[24 +: 8] = p_data[3];
    txq.push_back('{code: p_act[3], d: p_data[3], row: p_row[3], col: p_col[3]});
    bus.req[3] = 1'b1;
    repeat (6) @(negedge clk);
    chk("busy_blocks_active", bus.active, 0);
    chk("busy_blocks_action", bus.tx_action, 0);
    force_busy = 1'b0;
    begin
      int wait_b;
      wait_b = 0;
      while (!mbusy && wait_b < 10) begin @(negedge clk); wait_b++; end
      chk("busy_seen", mbusy, 1);
    end
    repeat (3) @(negedge clk);
    chk("wait_lo_active", bus.active, 1);
    do_reset();
    repeat (2) @(negedge clk);
    chk("post_rst_no_ack", bus.ack, 0);
    busy_n = 4;
    p_act[1] = 3'd1; p_data[1] = 8'hC3; p_row[1] = 1'b1; p_col[1] = 2'd0;
    phase(4'b0010);

    for (int n = 0; n < 40; n++) begin
      logic [NREQ-1:0] mask;
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      tx_respond = ($urandom_range(0, 4) != 0);
      busy_n = $urandom_range(1, 8);
      for (int i = 0; i < NREQ; i++) begin
        p_act[i]  = ($urandom_range(0, 9) < 2) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 5));
        p_row[i]  = 1'($urandom);
        p_col[i]  = 2'($urandom);
        p_data[i] = W'($urandom);
      end
      phase(mask);
    end

    repeat (5) @(negedge clk);
    chk("ackq_empty", ackq.size(), 0);
    chk("txq_empty", txq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
